// File: rtl/t05_wb_sram_responder.sv
// Wishbone B4 classic responder in front of a word-addressed, byte-lane-writable memory.
// Latency: ACK in the cycle after WAIT_CYCLES wait states; one access per WAIT_CYCLES+2 cycles minimum.
// Backpressure: classic cycle, manager holds cyc/stb until ACK; dropping cyc during a wait aborts.
module t05_wb_sram_responder #(
  parameter logic [31:0] ADDR_BASE   = 32'h3300_0000,
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        oor_o,
  output logic        busy_o
);

  localparam int          IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [32:0] WIN_LO   = {1'b0, ADDR_BASE};
  localparam logic [32:0] WIN_HI   = WIN_LO + 33'(4 * DEPTH_WORDS);
  localparam logic [31:0] OOR_DATA = 32'hBAD0_ADD2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] adr_q, dat_q;
  logic [3:0]  sel_q;
  logic        we_q;
  logic [31:0] rdat_q, rdat_d;
  logic        oor_q, oor_d;
  logic [31:0] mem_q [DEPTH_WORDS];

  // 33-bit compare so a window touching the top of the address space cannot wrap.
  function automatic logic in_win(input logic [31:0] a);
    return ({1'b0, a} >= WIN_LO) && ({1'b0, a} < WIN_HI);
  endfunction

  logic             take;
  logic [31:0]      acc_adr, acc_off, wr_off;
  logic             acc_we, acc_in, wr_in, mem_wr;
  logic [IDX_W-1:0] acc_idx, wr_idx;
  logic             unused_off;

  // A request is taken only in IDLE; with zero wait states ACK is entered on the
  // same edge, so the read path must look at the bus rather than the latch.
  assign take    = (state_q == ST_IDLE) & wbs_cyc_i & wbs_stb_i;
  assign acc_adr = take ? wbs_adr_i : adr_q;
  assign acc_we  = take ? wbs_we_i : we_q;
  assign acc_off = acc_adr - ADDR_BASE;
  assign acc_idx = acc_off[IDX_W+1:2];
  assign acc_in  = in_win(acc_adr);

  // Writes always use the latched request, committed on the edge leaving ACK.
  assign wr_off  = adr_q - ADDR_BASE;
  assign wr_idx  = wr_off[IDX_W+1:2];
  assign wr_in   = in_win(adr_q);
  assign mem_wr  = (state_q == ST_ACK) & we_q & wr_in;

  assign unused_off = ^{acc_off[31:IDX_W+2], acc_off[1:0], wr_off[31:IDX_W+2], wr_off[1:0]};

  // Next-state logic: IDLE -> WAIT (count) -> ACK -> IDLE, abort on cyc drop in WAIT.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (take) begin
          if (WAIT_CYCLES == 0) begin
            state_d = ST_ACK;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      ST_WAIT: begin
        if (!wbs_cyc_i) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          state_d = ST_ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Read data and the sticky out-of-range flag are loaded on the edge entering ACK.
  always_comb begin
    rdat_d = '0;
    oor_d  = oor_q;
    if (state_d == ST_ACK) begin
      if (!acc_we) rdat_d = acc_in ? mem_q[acc_idx] : OOR_DATA;
      if (!acc_in) oor_d = 1'b1;
    end
  end

  // Control state, latched request and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      rdat_q  <= '0;
      oor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdat_q  <= rdat_d;
      oor_q   <= oor_d;
      if (take) begin
        adr_q <= wbs_adr_i;
        dat_q <= wbs_dat_i;
        sel_q <= wbs_sel_i;
        we_q  <= wbs_we_i;
      end
    end
  end

  // Memory array: cleared by reset, byte-lane write when leaving ACK.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
    end else if (mem_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (sel_q[b]) mem_q[wr_idx][8*b +: 8] <= dat_q[8*b +: 8];
      end
    end
  end

  assign wbs_ack_o = (state_q == ST_ACK);
  assign wbs_dat_o = rdat_q;
  assign oor_o     = oor_q;
  assign busy_o    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_t05_wb_sram_responder.sv
// Bench for t05_wb_sram_responder: two instances (1 and 3 wait states) against a
// transaction-level model that predicts ack/busy/data/oor for every cycle.
module tb_t05_wb_sram_responder;

  localparam logic [31:0] BASE  = 32'h3300_0000;
  localparam int          DEPTH = 256;
  localparam int          WC0   = 1;
  localparam int          WC1   = 3;

  logic        clk = 1'b0;
  logic        rst_n [2];
  logic        cyc   [2];
  logic        stb   [2];
  logic        we    [2];
  logic [3:0]  sel   [2];
  logic [31:0] adr   [2];
  logic [31:0] wdat  [2];
  logic        ack   [2];
  logic [31:0] rdat  [2];
  logic        oor   [2];
  logic        busy  [2];

  // model state
  logic [31:0] mdl_mem [2][DEPTH];
  bit          mdl_oor [2];
  bit          exp_ack [2];
  bit          exp_busy[2];
  logic [31:0] exp_dat [2];
  bit          chk_dat [2];
  bit          chk_en;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  t05_wb_sram_responder #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WC0)) u_dut0 (
    .clk(clk), .rst_n(rst_n[0]), .wbs_cyc_i(cyc[0]), .wbs_stb_i(stb[0]), .wbs_we_i(we[0]),
    .wbs_sel_i(sel[0]), .wbs_adr_i(adr[0]), .wbs_dat_i(wdat[0]), .wbs_ack_o(ack[0]),
    .wbs_dat_o(rdat[0]), .oor_o(oor[0]), .busy_o(busy[0])
  );

  t05_wb_sram_responder #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WC1)) u_dut1 (
    .clk(clk), .rst_n(rst_n[1]), .wbs_cyc_i(cyc[1]), .wbs_stb_i(stb[1]), .wbs_we_i(we[1]),
    .wbs_sel_i(sel[1]), .wbs_adr_i(adr[1]), .wbs_dat_i(wdat[1]), .wbs_ack_o(ack[1]),
    .wbs_dat_o(rdat[1]), .oor_o(oor[1]), .busy_o(busy[1])
  );

  task automatic check(input string nm, input int d, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s dut%0d t=%0t: got %08h want %08h", nm, d, $time, got, want);
    end
  endtask

  function automatic bit in_win(input logic [31:0] a);
    longint unsigned la, lo, hi;
    la = {32'd0, a};
    lo = {32'd0, BASE};
    hi = lo + 64'(4 * DEPTH);
    return (la >= lo) && (la < hi);
  endfunction

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        check("ack", d, {31'd0, ack[d]}, {31'd0, exp_ack[d]});
        check("busy", d, {31'd0, busy[d]}, {31'd0, exp_busy[d]});
        check("oor", d, {31'd0, oor[d]}, {31'd0, mdl_oor[d]});
        if (chk_dat[d]) check("rdat", d, rdat[d], exp_dat[d]);
      end
    end
  end

  // One complete transaction; entered and left one step after a rising edge with the DUT idle.
  task automatic access(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] s, input bit keep, output logic [31:0] rd);
    int wc;
    bit inr;
    int wi;
    wc  = (d == 0) ? WC0 : WC1;
    inr = in_win(a);
    wi  = inr ? int'((a - BASE) >> 2) : 0;
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = wr; adr[d] = a; wdat[d] = wd; sel[d] = s;
    @(posedge clk); #1;
    // request is latched now; bus garbage must not matter
    adr[d]  = $urandom;
    wdat[d] = $urandom;
    sel[d]  = 4'($urandom_range(0, 15));
    exp_busy[d] = 1'b1;
    repeat (wc) begin @(posedge clk); #1; end
    exp_ack[d] = 1'b1;
    if (!wr) exp_dat[d] = inr ? mdl_mem[d][wi] : 32'hBAD0_ADD2;
    else     chk_dat[d] = 1'b0;
    if (!inr) mdl_oor[d] = 1'b1;
    rd = rdat[d];
    if (!keep) begin cyc[d] = 1'b0; stb[d] = 1'b0; end
    @(posedge clk); #1;
    exp_ack[d] = 1'b0; exp_busy[d] = 1'b0; exp_dat[d] = '0; chk_dat[d] = 1'b1;
    if (wr && inr) begin
      for (int b = 0; b < 4; b++) if (s[b]) mdl_mem[d][wi][8*b +: 8] = wd[8*b +: 8];
    end
  endtask

  initial begin
    logic [31:0] r, r1;
    chk_en = 1'b0;
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
      sel[d] = '0; adr[d] = '0; wdat[d] = '0;
      mdl_oor[d] = 1'b0; exp_ack[d] = 1'b0; exp_busy[d] = 1'b0; exp_dat[d] = '0; chk_dat[d] = 1'b1;
      for (int i = 0; i < DEPTH; i++) mdl_mem[d][i] = '0;
    end
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;

    // basic write / read-after-write
    access(0, 1'b1, BASE + 8, 32'hDEAD_BEEF, 4'hF, 1'b0, r);
    access(0, 1'b0, BASE + 8, 32'h0, 4'h0, 1'b0, r);
    check("raw_lit", 0, r, 32'hDEAD_BEEF);
    check("oor_clear", 0, {31'd0, oor[0]}, 32'd0);

    // byte lanes and empty select
    access(0, 1'b1, BASE + 12, 32'h1122_3344, 4'hF, 1'b0, r);
    access(0, 1'b1, BASE + 12, 32'hAABB_CCDD, 4'b0101, 1'b0, r);
    access(0, 1'b0, BASE + 12, 32'h0, 4'h0, 1'b0, r);
    check("lane_lit", 0, r, 32'h11BB_33DD);
    check("lane_mdl", 0, mdl_mem[0][3], 32'h11BB_33DD);
    access(0, 1'b1, BASE + 12, 32'hFFFF_FFFF, 4'h0, 1'b0, r);
    access(0, 1'b0, BASE + 12, 32'h0, 4'hF, 1'b0, r);
    check("sel0_lit", 0, r, 32'h11BB_33DD);

    // low address bits ignored; single upper lane
    access(0, 1'b0, BASE + 11, 32'h0, 4'h0, 1'b0, r);
    check("lowbits_lit", 0, r, 32'hDEAD_BEEF);
    access(0, 1'b1, BASE + 10, 32'h7700_0000, 4'b1000, 1'b0, r);
    access(0, 1'b0, BASE + 8, 32'h0, 4'h0, 1'b0, r);
    check("lane3_lit", 0, r, 32'h77AD_BEEF);

    // last word of the window
    access(0, 1'b1, BASE + 4 * (DEPTH - 1), 32'h7654_3210, 4'hF, 1'b0, r);
    access(0, 1'b0, BASE + 4 * (DEPTH - 1), 32'h0, 4'h0, 1'b0, r);
    check("top_lit", 0, r, 32'h7654_3210);

    // out of range on both sides
    access(0, 1'b0, BASE + 4 * DEPTH, 32'h0, 4'h0, 1'b0, r);
    check("oor_rd_lit", 0, r, 32'hBAD0_ADD2);
    check("oor_set", 0, {31'd0, oor[0]}, 32'd1);
    access(0, 1'b1, BASE - 4, 32'hFFFF_FFFF, 4'hF, 1'b0, r);
    access(0, 1'b0, BASE + 0, 32'h0, 4'h0, 1'b0, r);
    check("oor_w0", 0, r, 32'h0);
    access(0, 1'b0, BASE + 4 * (DEPTH - 1), 32'h0, 4'h0, 1'b0, r);
    check("oor_wtop", 0, r, 32'h7654_3210);

    // strobe held across two reads
    access(0, 1'b1, BASE + 4, 32'hA1A1_0001, 4'hF, 1'b0, r);
    access(0, 1'b1, BASE + 8, 32'hB2B2_0002, 4'hF, 1'b0, r);
    access(0, 1'b0, BASE + 4, 32'h0, 4'h0, 1'b1, r1);
    access(0, 1'b0, BASE + 8, 32'h0, 4'h0, 1'b0, r);
    check("stuck1_lit", 0, r1, 32'hA1A1_0001);
    check("stuck2_lit", 0, r, 32'hB2B2_0002);

    // three-wait-state instance
    access(1, 1'b1, BASE + 24, 32'h1234_5678, 4'hF, 1'b0, r);
    access(1, 1'b0, BASE + 24, 32'h0, 4'h0, 1'b0, r);
    check("w3_raw_lit", 1, r, 32'h1234_5678);

    // abort: cyc dropped in the second wait cycle
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = BASE; wdat[1] = 32'h5555_5555; sel[1] = 4'hF;
    @(posedge clk); #1;
    exp_busy[1] = 1'b1;
    @(posedge clk); #1;
    cyc[1] = 1'b0; stb[1] = 1'b0;
    @(posedge clk); #1;
    exp_busy[1] = 1'b0;
    @(posedge clk); #1;
    access(1, 1'b0, BASE + 0, 32'h0, 4'h0, 1'b0, r);
    check("abort_lit", 1, r, 32'h0);

    // set oor, then reset in the middle of a write to word 5
    access(1, 1'b0, BASE + 32'h1000, 32'h0, 4'h0, 1'b0, r);
    check("w3_oor_lit", 1, r, 32'hBAD0_ADD2);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = BASE + 20; wdat[1] = 32'hCAFE_F00D; sel[1] = 4'hF;
    @(posedge clk); #1;
    exp_busy[1] = 1'b1;
    rst_n[1] = 1'b0;
    @(posedge clk); #1;
    exp_busy[1] = 1'b0; mdl_oor[1] = 1'b0;
    for (int i = 0; i < DEPTH; i++) mdl_mem[1][i] = '0;
    cyc[1] = 1'b0; stb[1] = 1'b0; rst_n[1] = 1'b1;
    @(posedge clk); #1;
    check("rst_oor", 1, {31'd0, oor[1]}, 32'd0);
    access(1, 1'b0, BASE + 20, 32'h0, 4'h0, 1'b0, r);
    check("rst_w5_lit", 1, r, 32'h0);
    access(1, 1'b0, BASE + 24, 32'h0, 4'h0, 1'b0, r);
    check("rst_w6_lit", 1, r, 32'h0);

    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
